serial_add_ctrl: RTL and testbench

//   Bit-serial add/subtract sequencer for the 10-bit CPU datapath.

---
 rtl/serial_add_ctrl_if.sv | 29 ++
 rtl/serial_add_ctrl.sv | 97 +++++++++
 tb/tb_serial_add_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake and fulladder bus of the bit-serial add/subtract sequencer.
// The slave side is the sequencer; the master side is the CPU control unit together with the fulladder.
interface serial_add_ctrl_if #(parameter int WIDTH = 10);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;

  modport slave (
    input  start, op, a, b, fa_sum, fa_cout,
    output ready, busy, done, result, cout, overflow, fa_a, fa_b, fa_cin
  );

  modport master (
    output start, op, a, b, fa_sum, fa_cout,
    input  ready, busy, done, result, cout, overflow, fa_a, fa_b, fa_cin
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: streams operand bits LSB-first through an external fulladder,
// keeps the carry in a flop and assembles the result over WIDTH cycles.
module serial_add_ctrl #(
  parameter int WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q;
  logic             accept, last_bit;
  logic             ready_o, busy_o, done_o, fa_a_o, fa_b_o, fa_cin_o;

  assign accept   = (state_q == S_IDLE) && bus.start;
  assign last_bit = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_bit)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Fulladder inputs are forced low outside RUN so the shared adder sees quiet lines.
  always_comb begin
    ready_o  = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    fa_a_o   = 1'b0;
    fa_b_o   = 1'b0;
    fa_cin_o = 1'b0;
    case (state_q)
      S_IDLE: ready_o = 1'b1;
      S_RUN: begin
        busy_o   = 1'b1;
        fa_a_o   = a_sh_q[0];
        fa_b_o   = b_sh_q[0];
        fa_cin_o = carry_q;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Subtraction is a + ~b + 1: B is inverted on accept and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_sh_q  <= bus.a;
      b_sh_q  <= bus.op ? ~bus.b : bus.b;
      carry_q <= bus.op;
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      result_q <= {bus.fa_sum, result_q[WIDTH-1:1]};
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      carry_q  <= bus.fa_cout;
      cnt_q    <= cnt_q + 1'b1;
      if (last_bit) begin
        cout_q <= bus.fa_cout;
        ovf_q  <= carry_q ^ bus.fa_cout;
      end
    end
  end

  assign bus.ready    = ready_o;
  assign bus.busy     = busy_o;
  assign bus.done     = done_o;
  assign bus.fa_a     = fa_a_o;
  assign bus.fa_b     = fa_b_o;
  assign bus.fa_cin   = fa_cin_o;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed literal cases plus randomized traffic against
// an arithmetic reference model, with per-cycle checking of handshake and results.
module tb_serial_add_ctrl;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  serial_add_ctrl_if #(.WIDTH(W)) intf ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf.slave)
  );

  always #5 clk = ~clk;

  // Combinational fulladder shared with the sequencer.
  assign intf.fa_sum  = intf.fa_a ^ intf.fa_b ^ intf.fa_cin;
  assign intf.fa_cout = (intf.fa_a & intf.fa_b) | (intf.fa_a & intf.fa_cin) | (intf.fa_b & intf.fa_cin);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int sval(input logic [W-1:0] x);
    return x[W-1] ? int'(x) - (1 << W) : int'(x);
  endfunction

  // Reference model: tracks the edge on which an op was accepted and the expected results.
  int               cyc = 0;
  int               c0 = 0;
  bit               active = 1'b0;
  logic [W-1:0]     m_res = '0;
  logic             m_cout = 1'b0;
  logic             m_ovf = 1'b0;
  bit               chk_en = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 1'b0;
    end else begin
      cyc = cyc + 1;
      if ((!active || (cyc - 1 - c0) > W) && intf.start) begin
        int sa, sb, sr;
        active = 1'b1;
        c0     = cyc;
        sa     = sval(intf.a);
        sb     = sval(intf.b);
        if (!intf.op) begin
          m_res  = W'(int'(intf.a) + int'(intf.b));
          m_cout = (int'(intf.a) + int'(intf.b)) >= (1 << W);
          sr     = sa + sb;
        end else begin
          m_res  = W'(int'(intf.a) - int'(intf.b));
          m_cout = intf.a >= intf.b;
          sr     = sa - sb;
        end
        m_ovf = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int  k;
      bit  e_busy, e_done, e_ready;
      k       = cyc - c0;
      e_busy  = active && k < W;
      e_done  = active && k == W;
      e_ready = !active || k > W;
      chk("ready", intf.ready, e_ready);
      chk("busy", intf.busy, e_busy);
      chk("done", intf.done, e_done);
      if (!e_busy) begin
        chk("result", intf.result, active ? m_res : '0);
        chk("cout", intf.cout, active ? m_cout : 1'b0);
        chk("overflow", intf.overflow, active ? m_ovf : 1'b0);
        chk("fa_idle", {intf.fa_a, intf.fa_b, intf.fa_cin}, 3'b000);
      end
    end
  end

  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input bit glitch,
                        output logic [W-1:0] r, output logic c, output logic v, output int lat);
    int n;
    n = 0;
    while (!intf.ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!intf.ready) chk("ready_wait", 32'd0, 32'd1);
    intf.start = 1'b1; intf.op = o; intf.a = x; intf.b = y;
    @(posedge clk); #1;
    intf.start = 1'b0; intf.a = W'($urandom); intf.b = W'($urandom); intf.op = 1'($urandom);
    lat = 0;
    while (!intf.done && lat < 50) begin
      @(posedge clk); #1; lat++;
      intf.start = glitch && lat == 3;
      if (intf.start) begin
        intf.a = ~x; intf.b = ~y; intf.op = ~o;
      end
    end
    intf.start = 1'b0;
    if (!intf.done) chk("done_wait", 32'd0, 32'd1);
    r = intf.result; c = intf.cout; v = intf.overflow;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] r;
    logic         c, v;
    int           lat;
    intf.start = 1'b0; intf.op = 1'b0; intf.a = '0; intf.b = '0;
    #23;
    chk("rst_ready", intf.ready, 1'b1);
    chk("rst_result", intf.result, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 10'd3, 10'd5, 1'b0, r, c, v, lat);
    chk("add3_5_res", r, 10'd8); chk("add3_5_cout", c, 1'b0); chk("add3_5_ovf", v, 1'b0);
    chk("add3_5_lat", lat, W);
    run_op(1'b0, 10'd511, 10'd1, 1'b0, r, c, v, lat);
    chk("add511_1_res", r, 10'h200); chk("add511_1_cout", c, 1'b0); chk("add511_1_ovf", v, 1'b1);
    run_op(1'b0, 10'd1023, 10'd1, 1'b0, r, c, v, lat);
    chk("add1023_1_res", r, 10'd0); chk("add1023_1_cout", c, 1'b1); chk("add1023_1_ovf", v, 1'b0);
    run_op(1'b1, 10'd5, 10'd7, 1'b0, r, c, v, lat);
    chk("sub5_7_res", r, 10'h3FE); chk("sub5_7_cout", c, 1'b0);
    run_op(1'b1, 10'd7, 10'd5, 1'b0, r, c, v, lat);
    chk("sub7_5_res", r, 10'd2); chk("sub7_5_cout", c, 1'b1);
    run_op(1'b0, 10'd100, 10'd23, 1'b1, r, c, v, lat);
    chk("glitch_res", r, 10'd123); chk("glitch_lat", lat, W);
    // Next op starts the first cycle ready is back.
    run_op(1'b1, 10'd0, 10'd1, 1'b0, r, c, v, lat);
    chk("sub0_1_res", r, 10'h3FF); chk("sub0_1_cout", c, 1'b0); chk("sub0_1_lat", lat, W);

    // Abort an add at bit 4 with reset.
    @(posedge clk); #1;
    intf.start = 1'b1; intf.op = 1'b0; intf.a = 10'd300; intf.b = 10'd400;
    @(posedge clk); #1; intf.start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("abort_ready", intf.ready, 1'b1);
    chk("abort_result", intf.result, '0);
    chk("abort_done", intf.done, 1'b0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    run_op(1'b0, 10'd3, 10'd5, 1'b0, r, c, v, lat);
    chk("post_abort_res", r, 10'd8); chk("post_abort_lat", lat, W);

    // Randomized traffic including starts while busy; the model decides what is accepted.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      intf.start = ($urandom_range(0, 2) == 0);
      intf.op    = 1'($urandom);
      case ($urandom_range(0, 4))
        0: intf.a = 10'd511;
        1: intf.a = 10'd512;
        2: intf.a = 10'd1023;
        default: intf.a = W'($urandom);
      endcase
      intf.b = ($urandom_range(0, 3) == 0) ? intf.a : W'($urandom);
    end
    intf.start = 1'b0;
    repeat (W + 3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
